// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request,
// and a small instruction FIFO feeding decode, with redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        misaligned
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          drop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];

    logic req_fire;
    logic rsp_take;
    logic push;
    logic pop;

    assign imem_req_valid = rst_n && (state == IDLE)
                          && (count < FULL) && !redirect_valid;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response only counts while a request is outstanding.
    assign rsp_take = (state == WAIT) && imem_rsp_valid;
    assign push     = rsp_take && !drop && !redirect_valid;

    assign instr_valid    = rst_n && (count != '0);
    assign pop            = instr_valid && instr_ready && !redirect_valid;
    assign instr_out      = fifo_data[rd_ptr];
    assign instr_pc       = fifo_pc[rd_ptr];
    assign instr_pc_plus4 = instr_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            drop       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect_valid && (redirect_target[1:0] != 2'b00);
            if (redirect_valid) begin
                pc     <= {redirect_target[31:2], 2'b00};
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                // An in-flight request becomes stale; a response that
                // lands this very cycle is discarded right here instead.
                if (state == WAIT) begin
                    if (imem_rsp_valid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
            end else begin
                if (req_fire) begin
                    req_pc <= pc;
                    pc     <= pc + 32'd4;
                    state  <= WAIT;
                end
                if (rsp_take) begin
                    state <= IDLE;
                    if (drop) begin
                        drop <= 1'b0;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall,
// redirect/drop handling, misalignment, PC wrap and mid-WAIT reset.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        misaligned;

    int nvec = 0;
    int nerr = 0;
    int mem_lat = 1;
    int pend = 0;
    logic [31:0] paddr;

    logic [31:0] req_log [$];
    logic [31:0] pc_log  [$];
    logic [31:0] dat_log [$];
    logic [31:0] p4_log  [$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .instr_pc_plus4  (instr_pc_plus4),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned      (misaligned)
    );

    // One clock: log handshakes/pops, then model a fixed-latency memory.
    task automatic tick();
        logic hs;
        logic [31:0] a;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_addr;
        if (hs) req_log.push_back(a);
        if (instr_valid && instr_ready && !redirect_valid && rst_n) begin
            pc_log.push_back(instr_pc);
            dat_log.push_back(instr_out);
            p4_log.push_back(instr_pc_plus4);
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (hs) begin
            pend  = mem_lat;
            paddr = a;
        end
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = paddr ^ MAGIC;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend           = 0;
        tick();
        tick();
        rst_n = 1'b1;
        req_log.delete();
        pc_log.delete();
        dat_log.delete();
        p4_log.delete();
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        tick();
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
        nvec++; if (misaligned !== 1'b0) begin nerr++; $display("FAIL rst_misaligned got %b exp 0", misaligned); end
    endtask

    task automatic test_stream();
        do_reset();
        instr_ready = 1'b1;
        mem_lat = 1;
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin nerr++; $display("FAIL stream_first_req got %b/%h exp 1/00000000", imem_req_valid, imem_addr); end
        tick();
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL stream_lat_n1 got %b exp 0", instr_valid); end
        tick();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin nerr++; $display("FAIL stream_lat_n2 got %b/%h exp 1/00000000", instr_valid, instr_pc); end
        for (int i = 0; i < 8; i++) tick();
        nvec++; if (req_log.size() < 3 || pc_log.size() < 3) begin
            nerr++; $display("FAIL stream_count got %0d/%0d exp >=3/>=3", req_log.size(), pc_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nvec++; if (req_log[i] !== 32'(4 * i)) begin nerr++; $display("FAIL stream_addr%0d got %h exp %h", i, req_log[i], 32'(4 * i)); end
                nvec++; if (pc_log[i] !== 32'(4 * i)) begin nerr++; $display("FAIL stream_pc%0d got %h exp %h", i, pc_log[i], 32'(4 * i)); end
                nvec++; if (dat_log[i] !== (MAGIC | 32'(4 * i))) begin nerr++; $display("FAIL stream_data%0d got %h exp %h", i, dat_log[i], MAGIC | 32'(4 * i)); end
                nvec++; if (p4_log[i] !== 32'(4 * i + 4)) begin nerr++; $display("FAIL stream_p4_%0d got %h exp %h", i, p4_log[i], 32'(4 * i + 4)); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b0;
        mem_lat = 1;
        for (int i = 0; i < 10; i++) tick();
        nvec++; if (req_log.size() != 2) begin nerr++; $display("FAIL stall_nreq got %0d exp 2", req_log.size()); end
        else begin
            nvec++; if (req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin nerr++; $display("FAIL stall_addrs got %h,%h exp 0,4", req_log[0], req_log[1]); end
        end
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL stall_req_held got %b exp 0", imem_req_valid); end
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin nerr++; $display("FAIL stall_head got %b/%h exp 1/00000000", instr_valid, instr_pc); end
        instr_ready = 1'b1;
        #1;
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL stall_pop_cycle_req got %b exp 0", imem_req_valid); end
        tick();
        instr_ready = 1'b0;
        #1;
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin nerr++; $display("FAIL stall_resume got %b/%h exp 1/00000008", imem_req_valid, imem_addr); end
        nvec++; if (instr_pc !== 32'h4) begin nerr++; $display("FAIL stall_next_head got %h exp 00000004", instr_pc); end
    endtask

    task automatic test_redirect_drop();
        mem_lat = 3;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL drop_redir_req got %b exp 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL drop_flush got %b exp 0", instr_valid); end
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL drop_wait1 got %b exp 0", imem_req_valid); end
        tick();
        nvec++; if (imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin nerr++; $display("FAIL drop_wait2 got %b/%b exp 0/1", imem_req_valid, imem_rsp_valid); end
        tick();
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            nerr++; $display("FAIL drop_after got %b/%h/%b exp 1/00000100/0", imem_req_valid, imem_addr, instr_valid);
        end
        mem_lat = 1;
        instr_ready = 1'b1;
        pc_log.delete();
        dat_log.delete();
        for (int i = 0; i < 6; i++) tick();
        nvec++; if (pc_log.size() < 2) begin nerr++; $display("FAIL drop_deliver_n got %0d exp >=2", pc_log.size()); end
        else begin
            nvec++; if (pc_log[0] !== 32'h100 || dat_log[0] !== 32'hA5A5_0100) begin nerr++; $display("FAIL drop_first got %h/%h exp 00000100/a5a50100", pc_log[0], dat_log[0]); end
            nvec++; if (pc_log[1] !== 32'h104) begin nerr++; $display("FAIL drop_second got %h exp 00000104", pc_log[1]); end
        end
    endtask

    task automatic test_redirect_no_drop();
        int n;
        do_reset();
        instr_ready = 1'b1;
        mem_lat = 1;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        #1;
        nvec++; if (imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin nerr++; $display("FAIL same_cyc_setup got %b/%b exp 0/1", imem_req_valid, imem_rsp_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
            nerr++; $display("FAIL same_cyc_next got %b/%h/%b exp 1/00000040/0", imem_req_valid, imem_addr, instr_valid);
        end
        tick();
        tick();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_out !== 32'hA5A5_0040) begin
            nerr++; $display("FAIL same_cyc_nodrop got %b/%h/%h exp 1/00000040/a5a50040", instr_valid, instr_pc, instr_out);
        end
        n = req_log.size();
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        #1;
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL idle_redir_req got %b exp 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        nvec++; if (req_log.size() != n) begin nerr++; $display("FAIL idle_redir_hs got %0d exp %0d", req_log.size(), n); end
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h80 || instr_valid !== 1'b0) begin
            nerr++; $display("FAIL idle_redir_next got %b/%h/%b exp 1/00000080/0", imem_req_valid, imem_addr, instr_valid);
        end
        tick();
        tick();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin nerr++; $display("FAIL idle_redir_deliver got %b/%h exp 1/00000080", instr_valid, instr_pc); end
    endtask

    task automatic test_misaligned();
        redirect_valid  = 1'b1;
        redirect_target = 32'h203;
        #1;
        nvec++; if (misaligned !== 1'b0) begin nerr++; $display("FAIL mis_before got %b exp 0", misaligned); end
        tick();
        redirect_valid = 1'b0;
        #1;
        nvec++; if (misaligned !== 1'b1) begin nerr++; $display("FAIL mis_pulse got %b exp 1", misaligned); end
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin nerr++; $display("FAIL mis_addr got %b/%h exp 1/00000200", imem_req_valid, imem_addr); end
        tick();
        nvec++; if (misaligned !== 1'b0) begin nerr++; $display("FAIL mis_clear got %b exp 0", misaligned); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        nvec++; if (imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        tick();
        tick();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr_pc_plus4 !== 32'h0) begin
            nerr++; $display("FAIL wrap_head got %b/%h/%h exp 1/fffffffc/00000000", instr_valid, instr_pc, instr_pc_plus4);
        end
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin nerr++; $display("FAIL wrap_next got %b/%h exp 1/00000000", imem_req_valid, imem_addr); end
        instr_ready = 1'b0;
        mem_lat = 3;
        tick();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        nvec++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin nerr++; $display("FAIL midwait_in_rst got %b/%b exp 0/0", imem_req_valid, instr_valid); end
        rst_n = 1'b1;
        #1;
        nvec++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            nerr++; $display("FAIL midwait_after got %b/%h/%b exp 1/00000000/0", imem_req_valid, imem_addr, instr_valid);
        end
        tick();
        nvec++; if (imem_rsp_valid !== 1'b1 || instr_valid !== 1'b0) begin nerr++; $display("FAIL late_rsp_cyc got %b/%b exp 1/0", imem_rsp_valid, instr_valid); end
        tick();
        nvec++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1) begin nerr++; $display("FAIL late_rsp_ignored got %b/%b exp 0/1", instr_valid, imem_req_valid); end
        imem_req_ready = 1'b1;
        mem_lat = 1;
        tick();
        tick();
        nvec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== MAGIC) begin
            nerr++; $display("FAIL post_rst_fetch got %b/%h/%h exp 1/00000000/a5a50000", instr_valid, instr_pc, instr_out);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_no_drop();
        test_misaligned();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the immediate extender and decoder in the RISC-V core.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PC in a small FIFO and presents them to decode. Decode slices instr_out[31:7] into the extender.
- Accepts redirects (branch/jump target = PC + ImmExt) from execute and flushes the wrong-path state.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
DEPTH, 2, instruction FIFO entries (power of 2, ≥2).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request.
imem_addr  output  32  word address of request (bits[1:0] always 0).
imem_rsp_valid  input  1  read data valid, in order, at least 1 cycle after request handshake.
imem_rsp_data  input  32  fetched instruction word.
instr_valid  output  1  FIFO head valid.
instr_ready  input  1  decode consumes head.
instr_out  output  32  instruction at FIFO head.
instr_pc  output  32  PC of instr_out.
instr_pc_plus4  output  32  instr_pc + 4, mod 2^32.
redirect_valid  input  1  redirect PC this cycle.
redirect_target  input  32  new PC.
misaligned  output  1  registered one-cycle pulse: redirect_target[1:0] != 0.

Behaviour:
- Reset (rst_n low at edge):
  - pc = RESET_PC; state = IDLE; FIFO count = 0; drop = 0; misaligned = 0.
  - Outputs during reset: imem_req_valid = 0 and instr_valid = 0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding. At most one request is outstanding at any time.
- imem_req_valid = (state==IDLE) && (count < DEPTH) && !redirect_valid. imem_addr = pc.
- IDLE, request handshake: req_pc <= pc; pc <= pc + 4 (wraps at 2^32); state <= WAIT.
- WAIT, imem_rsp_valid:
  - If drop = 0, push {req_pc, imem_rsp_data}.
  - Otherwise discard and clear drop.
  - state <= IDLE in both cases.
  - Push never overflows, because a request is only issued with a free slot.
- imem_rsp_valid in IDLE is ignored.
- Output: instr_valid = (count != 0). instr_out, instr_pc and instr_pc_plus4 are driven from the FIFO head.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Redirect (redirect_valid = 1), highest priority:
  - pc <= {redirect_target[31:2], 2'b00}; FIFO flushed (count = 0, pointers reset).
  - Any same-cycle pop or push is discarded.
  - If state == WAIT and no response arrives this cycle: drop <= 1, state stays WAIT.
  - If state == WAIT and a response arrives this cycle: the response is discarded, drop stays 0, state <= IDLE.
  - misaligned <= (redirect_target[1:0] != 0). It is 0 in every cycle without a redirect.
- Back-to-back redirects: the last one wins. drop stays set until the stale response returns.
- Latency with a zero-wait memory (rsp one cycle after handshake): request cycle N, response N+1, instr_valid at N+2.
- Peak throughput: one instruction per 2 cycles.
- Decode stall: with instr_ready held low, fetch stops once count == DEPTH and resumes the cycle after the first pop.
- A reset mid-WAIT abandons the outstanding request. A late response arriving in IDLE after reset is ignored.

Test Plan:
1. Reset with RESET_PC=0, always-ready memory (1-cycle rsp), instr_ready=1 → addresses 0x0, 0x4, 0x8. instr_pc sequence 0x0, 0x4, 0x8 with matching data. instr_pc_plus4 = 0x4, 0x8, 0xC.
2. instr_ready=0 for 10 cycles → exactly 2 requests (0x0, 0x4). imem_req_valid then held 0 and count=2. Raising instr_ready pops 0x0; next request to 0x8 follows one cycle later.
3. Redirect to 0x100 while WAIT on 0x8, response arrives 2 cycles later → that response is dropped. Next request addr=0x100. First delivered instr_pc=0x100, with no 0x8 or buffered 0x4 emitted.
4. Redirect in the same cycle as the response, and redirect in IDLE while imem_req_ready=1 → no handshake that cycle. Next addr = target. drop not set, so no valid response is lost.
5. Redirect target 0x203 → misaligned pulses for 1 cycle. Next addr=0x200.
6. pc=0xFFFF_FFFC fetch → next addr 0x0000_0000, instr_pc_plus4=0x0. rst_n low mid-WAIT → next request at RESET_PC, FIFO empty.
